// File: rtl/p09_video_out.sv
// p09_video_out: delays sync/blank/line/frame markers by PIPE_DEPTH pixel ticks,
// gates colour with display enable and counts frames.
module p09_video_out #(
  parameter int   PIPE_DEPTH = 2,
  parameter int   COLOR_BITS = 2,
  parameter int   CNT_W      = 11,
  parameter logic SYNC_IDLE  = 1'b1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic                    hsync_in,
  input  logic                    vsync_in,
  input  logic                    hblank_in,
  input  logic                    vblank_in,
  input  logic signed [CNT_W-1:0] h_counter,
  input  logic signed [CNT_W-1:0] v_counter,
  input  logic [3*COLOR_BITS-1:0] rgb_in,
  output logic                    hsync,
  output logic                    vsync,
  output logic                    de,
  output logic [3*COLOR_BITS-1:0] rgb_out,
  output logic                    line_start,
  output logic                    frame_start,
  output logic [7:0]              frame_count
);
  localparam int W = 5 * PIPE_DEPTH;
  localparam logic [4:0] IDLE = {SYNC_IDLE, SYNC_IDLE, 3'b000};
  logic [W-1:0]            r_pipe;
  logic [3*COLOR_BITS-1:0] r_rgb;
  logic                    r_en_d;
  logic [7:0]              r_fc;
  logic [W-1:0]            w_shift;
  logic [4:0]              w_tuple;
  logic [4:0]              w_next;
  logic [4:0]              w_last;
  logic                    w_sol;
  assign w_sol   = h_counter == '0;
  assign w_tuple = {hsync_in, vsync_in, ~(hblank_in | vblank_in), w_sol, w_sol && v_counter == '0};
  // Stage 0 sits in the low bits; the final stage is the top 5 bits.
  if (PIPE_DEPTH == 1) begin : g_one
    assign w_shift = w_tuple;
  end else begin : g_many
    assign w_shift = {r_pipe[W-6:0], w_tuple};
  end
  assign w_next = w_shift[W-1 -: 5];
  assign w_last = r_pipe[W-1 -: 5];
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pipe <= {PIPE_DEPTH{IDLE}};
      r_rgb  <= '0;
      r_en_d <= 1'b0;
      r_fc   <= '0;
    end else begin
      if (enable) begin
        r_pipe <= w_shift;
        r_rgb  <= w_next[2] ? rgb_in : '0;
      end
      r_en_d <= enable;
      r_fc   <= r_fc + {7'd0, frame_start};
    end
  end
  // Markers last only the cycle right after the enable edge that loaded them.
  assign hsync       = w_last[4];
  assign vsync       = w_last[3];
  assign de          = w_last[2];
  assign line_start  = w_last[1] & r_en_d;
  assign frame_start = w_last[0] & r_en_d;
  assign rgb_out     = r_rgb;
  assign frame_count = r_fc;
endmodule
